// File: rtl/cpu_pkg.sv
`default_nettype none
// ============================================================================
// Module      : cpu_pkg
// Description : Constants shared by the control sequencer, ALU and datapath.
//               It holds the sequencer state codes, the instruction opcodes,
//               the ALU operation codes, and the opcode-class type produced by
//               op_decode.
// Revision    : 1.0 - initial release
// ============================================================================
package cpu_pkg;

    // Sequencer state codes. These are also the values shown on the debug
    // output 'step'.
    localparam logic [2:0] c_ST_T0   = 3'd0;
    localparam logic [2:0] c_ST_T1   = 3'd1;
    localparam logic [2:0] c_ST_T2   = 3'd2;
    localparam logic [2:0] c_ST_T3   = 3'd3;
    localparam logic [2:0] c_ST_T4   = 3'd4;
    localparam logic [2:0] c_ST_T5   = 3'd5;
    localparam logic [2:0] c_ST_HALT = 3'd6;

    // Instruction opcodes, taken from IR[31:27].
    localparam logic [4:0] c_OP_ADD  = 5'b00011;
    localparam logic [4:0] c_OP_SUB  = 5'b00100;
    localparam logic [4:0] c_OP_AND  = 5'b00101;
    localparam logic [4:0] c_OP_OR   = 5'b00110;
    localparam logic [4:0] c_OP_ADDI = 5'b01100;
    localparam logic [4:0] c_OP_HALT = 5'b11011;

    // ALU operation codes. PASS (0) is the idle value.
    localparam logic [3:0] c_ALU_PASS = 4'h0;
    localparam logic [3:0] c_ALU_ADD  = 4'h1;
    localparam logic [3:0] c_ALU_SUB  = 4'h2;
    localparam logic [3:0] c_ALU_AND  = 4'h3;
    localparam logic [3:0] c_ALU_OR   = 4'h4;

    // Opcode class: decides how the sequencer leaves T3.
    typedef enum logic [1:0] {
        CLS_NOP  = 2'd0,
        CLS_RFMT = 2'd1,
        CLS_IMM  = 2'd2,
        CLS_HALT = 2'd3
    } op_class_t;

    function automatic logic [4:0] opcode_of(input logic [31:0] ir);
        return ir[31:27];
    endfunction

endpackage
`default_nettype wire

// File: rtl/control_sequencer_if.sv
`default_nettype none
// ============================================================================
// Module      : control_sequencer_if
// Description : Bundle of the signals between the control sequencer and the
//               datapath.
//               Inputs to the sequencer:
//                 IR        - instruction word
//                 mem_ready - memory read data is valid
//                 Stop      - request a halt
//               Outputs from the sequencer:
//                 transfer strobes
//                 register-select strobes
//                 alu_op    - ALU operation select
//                 Run       - high while not halted
//                 step      - current state, for debug
//               The master modport is the sequencer side.
//               The slave modport is the datapath side.
// Revision    : 1.0 - initial release
// ============================================================================
interface control_sequencer_if;
    logic [31:0] IR;
    logic        mem_ready;
    logic        Stop;
    logic        PCout, IncPC, PCin, MARin, Zin, Zlowout;
    logic        Read, MDRin, MDRout, IRin, Yin, Cout;
    logic        Gra, Grb, Grc, Rin, Rout;
    logic [3:0]  alu_op;
    logic        Run;
    logic [2:0]  step;

    modport master (
        input  IR, mem_ready, Stop,
        output PCout, IncPC, PCin, MARin, Zin, Zlowout, Read, MDRin, MDRout,
               IRin, Yin, Cout, Gra, Grb, Grc, Rin, Rout, alu_op, Run, step
    );

    modport slave (
        output IR, mem_ready, Stop,
        input  PCout, IncPC, PCin, MARin, Zin, Zlowout, Read, MDRin, MDRout,
               IRin, Yin, Cout, Gra, Grb, Grc, Rin, Rout, alu_op, Run, step
    );
endinterface
`default_nettype wire

// File: rtl/control_sequencer_op_decode.sv
`default_nettype none
// ============================================================================
// Module      : op_decode
// Description : Maps an opcode to its class and ALU operation.
//               Ports:
//                 i_opcode - IR[31:27]
//                 o_class  - opcode class (NOP / R-format / immediate / halt)
//                 o_alu_op - ALU operation used in T4
//               ADDI is decoded to the ADD ALU code.
// Revision    : 1.0 - initial release
// ============================================================================
module op_decode
    import cpu_pkg::*;
#(
    parameter logic [4:0] OP_ADD  = c_OP_ADD,
    parameter logic [4:0] OP_SUB  = c_OP_SUB,
    parameter logic [4:0] OP_AND  = c_OP_AND,
    parameter logic [4:0] OP_OR   = c_OP_OR,
    parameter logic [4:0] OP_ADDI = c_OP_ADDI,
    parameter logic [4:0] OP_HALT = c_OP_HALT
) (
    input  wire logic [4:0] i_opcode,
    output op_class_t       o_class,
    output logic [3:0]      o_alu_op
);

    always_comb begin
        o_class  = CLS_NOP;
        o_alu_op = c_ALU_PASS;
        if (i_opcode == OP_ADD) begin
            o_class  = CLS_RFMT;
            o_alu_op = c_ALU_ADD;
        end else if (i_opcode == OP_SUB) begin
            o_class  = CLS_RFMT;
            o_alu_op = c_ALU_SUB;
        end else if (i_opcode == OP_AND) begin
            o_class  = CLS_RFMT;
            o_alu_op = c_ALU_AND;
        end else if (i_opcode == OP_OR) begin
            o_class  = CLS_RFMT;
            o_alu_op = c_ALU_OR;
        end else if (i_opcode == OP_ADDI) begin
            o_class  = CLS_IMM;
            o_alu_op = c_ALU_ADD;
        end else if (i_opcode == OP_HALT) begin
            o_class  = CLS_HALT;
        end
    end

endmodule
`default_nettype wire

// File: rtl/control_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : control_sequencer
// Description : Moore-style control sequencer that runs the
//               fetch / decode / execute steps T0..T5, plus a HALT state.
//               Ports:
//                 Clock - system clock, rising edge
//                 clear - synchronous, active-high reset
//                 bus   - master side of control_sequencer_if
//                         (IR, mem_ready, Stop in; strobes, alu_op, Run,
//                         step out)
//               The opcode is latched from IR on the edge that leaves T2.
//               This is the same edge on which the datapath loads IRin, so
//               IR must carry the fetched word during T2.
// Revision    : 1.0 - initial release
// ============================================================================
module control_sequencer
    import cpu_pkg::*;
#(
    parameter logic [4:0] OP_ADD  = c_OP_ADD,
    parameter logic [4:0] OP_SUB  = c_OP_SUB,
    parameter logic [4:0] OP_AND  = c_OP_AND,
    parameter logic [4:0] OP_OR   = c_OP_OR,
    parameter logic [4:0] OP_ADDI = c_OP_ADDI,
    parameter logic [4:0] OP_HALT = c_OP_HALT
) (
    input wire logic            Clock,
    input wire logic            clear,
    control_sequencer_if.master bus
);

    logic [2:0] r_state;
    logic [2:0] w_next;
    logic [4:0] r_opcode;
    logic       r_t1_wait;   // set on every T1 cycle after the first one
    op_class_t  w_class;
    logic [3:0] w_alu;

    op_decode #(
        .OP_ADD  (OP_ADD),
        .OP_SUB  (OP_SUB),
        .OP_AND  (OP_AND),
        .OP_OR   (OP_OR),
        .OP_ADDI (OP_ADDI),
        .OP_HALT (OP_HALT)
    ) u_op_decode (
        .i_opcode (r_opcode),
        .o_class  (w_class),
        .o_alu_op (w_alu)
    );

    always_ff @(posedge Clock) begin
        if (clear) begin
            r_state   <= c_ST_T0;
            r_opcode  <= 5'd0;
            r_t1_wait <= 1'b0;
        end else begin
            r_state   <= w_next;
            r_t1_wait <= (r_state == c_ST_T1) && !bus.mem_ready;
            if (r_state == c_ST_T2) begin
                r_opcode <= opcode_of(bus.IR);
            end
        end
    end

    always_comb begin
        w_next      = r_state;
        bus.PCout   = 1'b0;
        bus.IncPC   = 1'b0;
        bus.PCin    = 1'b0;
        bus.MARin   = 1'b0;
        bus.Zin     = 1'b0;
        bus.Zlowout = 1'b0;
        bus.Read    = 1'b0;
        bus.MDRin   = 1'b0;
        bus.MDRout  = 1'b0;
        bus.IRin    = 1'b0;
        bus.Yin     = 1'b0;
        bus.Cout    = 1'b0;
        bus.Gra     = 1'b0;
        bus.Grb     = 1'b0;
        bus.Grc     = 1'b0;
        bus.Rin     = 1'b0;
        bus.Rout    = 1'b0;
        bus.alu_op  = c_ALU_PASS;
        bus.Run     = 1'b1;
        bus.step    = r_state;
        if (clear) begin
            // While clear is held, the outputs stay idle whatever the state.
            w_next   = c_ST_T0;
            bus.step = c_ST_T0;
        end else begin
            case (r_state)
                c_ST_T0: begin
                    // A Stop in T0 halts before any fetch strobe is issued.
                    if (bus.Stop) begin
                        w_next = c_ST_HALT;
                    end else begin
                        bus.PCout = 1'b1;
                        bus.MARin = 1'b1;
                        bus.IncPC = 1'b1;
                        bus.Zin   = 1'b1;
                        w_next    = c_ST_T1;
                    end
                end
                c_ST_T1: begin
                    bus.Zlowout = 1'b1;
                    bus.Read    = 1'b1;
                    bus.MDRin   = 1'b1;
                    // Load the incremented PC only once, even across wait
                    // states.
                    bus.PCin    = !r_t1_wait;
                    if (bus.mem_ready) begin
                        w_next = c_ST_T2;
                    end
                end
                c_ST_T2: begin
                    bus.MDRout = 1'b1;
                    bus.IRin   = 1'b1;
                    w_next     = c_ST_T3;
                end
                c_ST_T3: begin
                    case (w_class)
                        CLS_HALT: w_next = c_ST_HALT;
                        CLS_RFMT, CLS_IMM: begin
                            bus.Grb  = 1'b1;
                            bus.Rout = 1'b1;
                            bus.Yin  = 1'b1;
                            w_next   = c_ST_T4;
                        end
                        default: w_next = c_ST_T0;
                    endcase
                end
                c_ST_T4: begin
                    bus.Zin    = 1'b1;
                    bus.alu_op = w_alu;
                    if (w_class == CLS_IMM) begin
                        bus.Cout = 1'b1;
                    end else begin
                        bus.Grc  = 1'b1;
                        bus.Rout = 1'b1;
                    end
                    w_next = c_ST_T5;
                end
                c_ST_T5: begin
                    bus.Zlowout = 1'b1;
                    bus.Gra     = 1'b1;
                    bus.Rin     = 1'b1;
                    w_next      = c_ST_T0;
                end
                c_ST_HALT: begin
                    bus.Run = 1'b0;
                    w_next  = c_ST_HALT;
                end
                default: w_next = c_ST_T0;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: doc/control_sequencer.md
CONTROL_SEQUENCER -- requirements
Module: control_sequencer

Interface
REQ-001 SHALL have port: Clock  input  1  single system clock; all state changes on rising edge.
REQ-002 SHALL have port: clear  input  1  synchronous, active-high reset.
REQ-003 SHALL have port: IR  input  32  instruction register contents; opcode IR[31:27].
REQ-004 SHALL have port: mem_ready  input  1  memory read data valid on Mdatain this cycle.
REQ-005 SHALL have port: Stop  input  1  request halt at next instruction boundary.
REQ-006 SHALL have ports: PCout, IncPC, PCin, MARin, Zin, Zlowout, Read, MDRin, MDRout, IRin, Yin, Cout  output  1 each  datapath transfer strobes.
REQ-007 SHALL have ports: Gra, Grb, Grc, Rin, Rout  output  1 each  register-select and enable strobes.
REQ-008 SHALL have port: alu_op  output  4  ALU operation select.
REQ-009 SHALL have port: Run  output  1  high while not halted.
REQ-010 SHALL have port: step  output  3  current state encoding, for debug.
REQ-011 SHALL use parameter: OP_ADD, default 5'b00011, R-format add.
REQ-012 SHALL use parameter: OP_SUB, default 5'b00100; OP_AND, default 5'b00101; OP_OR, default 5'b00110; OP_ADDI, default 5'b01100; OP_HALT, default 5'b11011.

Function
REQ-013 SHALL be a Moore FSM with states T0, T1, T2, T3, T4, T5, HALT; every output is a function of state and registered IR only.
REQ-014 SHALL, in T0, assert PCout, MARin, IncPC, Zin; next state T1.
REQ-015 SHALL, in T1, assert Zlowout, PCin, Read, MDRin; remain in T1 while mem_ready=0, leave for T2 when mem_ready=1; PCin asserted only in the first T1 cycle.
REQ-016 SHALL, in T2, assert MDRout, IRin; next state T3.
REQ-017 SHALL, in T3, decode IR[31:27]: OP_HALT -> HALT; ADD/SUB/AND/OR/ADDI -> assert Grb, Rout, Yin, next T4; any other opcode -> no strobes, next T0 (NOP).
REQ-018 SHALL, in T4, assert Zin and drive alu_op from opcode; R-format ops assert Grc, Rout; OP_ADDI asserts Cout with alu_op = ADD code.
REQ-019 SHALL, in T5, assert Zlowout, Gra, Rin; next state T0.
REQ-020 SHALL hold alu_op at 4'h0 (pass/idle) in every state except T4.
REQ-021 SHALL sample Stop only in T0; Stop=1 in T0 -> HALT with no T0 strobes asserted that cycle.
REQ-022 SHALL deassert Run and all strobes in HALT; HALT is left only by clear.
REQ-023 SHALL never assert more than one bus-driving strobe (PCout, Zlowout, MDRout, Rout, Cout) in the same cycle.
REQ-024 SHALL give a zero-wait-state R-format or ADDI instruction a latency of exactly 6 cycles T0..T5; each mem_ready=0 cycle adds one.

Reset
REQ-025 SHALL, when clear=1 at a rising edge, enter T0 next cycle regardless of current state, including mid-T1 wait and HALT.
REQ-026 SHALL, during and after reset until first T0 edge, drive all strobes 0, alu_op 4'h0, Run 1, step 3'd0.

Structure
REQ-027 SHALL take opcode constants, ALU op codes and state encoding from shared package cpu_pkg, also used by the ALU and datapath.
REQ-028 SHALL contain one sub-module, op_decode, mapping IR[31:27] to op class and alu_op; remainder is the state register and output logic.

Verification
REQ-029 SHALL verify fetch: clear then mem_ready=1 constant -> T0,T1,T2 strobes each exactly one cycle, step 0,1,2.
REQ-030 SHALL verify wait states: mem_ready=0 for 3 cycles in T1 -> Read/MDRin held 4 cycles, PCin 1 cycle, IRin once after mem_ready rises.
REQ-031 SHALL verify ADD: IR=32'h1A080000 (op 00011) -> T3 Grb/Rout/Yin, T4 Grc/Rout/Zin alu_op=ADD, T5 Gra/Rin, back to T0 at cycle 6.
REQ-032 SHALL verify ADDI: IR opcode 01100 -> T4 asserts Cout, not Grc; alu_op=ADD.
REQ-033 SHALL verify halt: IR opcode 11011 -> HALT after T3, Run=0, all strobes 0 for 20 cycles; Stop=1 at T0 likewise halts; clear returns to T0 with Run=1.
REQ-034 SHALL verify reset mid-operation: clear=1 in T4 -> next cycle T0, no Zin/Rin pulse, plus illegal opcode 5'b11111 -> T3 then T0 with no strobes.
